// File: rtl/multibank_prefetch_buffer.sv
// Tile prefetch buffer: fetches a tile in read-master bursts into an FWFT FIFO, then serves
// recirculating or consuming pops. Optional sticky error flags are enabled with MBPB_ERR_EN.
module multibank_prefetch_buffer #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 64,
    parameter int BURST_LEN       = 4,
    parameter int TOTAL_BYTES     = 63232,
    parameter int FIFO_ADDR_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     op_start,
    input  logic                     end_conv,
    input  logic                     recirc_en,
    input  logic [ADDR_WIDTH-1:0]    addr_base,
    output logic                     rmst_req,
    input  logic                     rmst_done,
    output logic [ADDR_WIDTH-1:0]    addr_offset,
    input  logic [DATA_WIDTH-1:0]    tdata,
    input  logic                     valid,
    output logic                     ready,
    input  logic                     pop_req,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic                     buf_rdy,
    output logic [FIFO_ADDR_WIDTH:0] word_cnt
`ifdef MBPB_ERR_EN
    ,
    output logic [2:0]               err
`endif
);

    localparam int BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam int NUM_BURSTS  = (TOTAL_BYTES + BURST_BYTES - 1) / BURST_BYTES;
    localparam int DEPTH       = 2 ** FIFO_ADDR_WIDTH;
    localparam int BIDX_W      = $clog2(NUM_BURSTS + 1);
    localparam int CW          = FIFO_ADDR_WIDTH + 1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_READY} state_t;

    state_t                     state, state_next;
    logic [DATA_WIDTH-1:0]      mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]              count, count_next;
    logic [BIDX_W-1:0]          burst_idx;
    logic                       empty, full, load_phase;
    logic                       push_beat, pop_fire, pop_keep, pop_drop;
    logic                       space_ok, last_burst, mem_we;
    logic [DATA_WIDTH-1:0]      mem_wdata;

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign load_phase = (state == S_REQ) || (state == S_WAIT) || (state == S_HOLD);
    assign ready      = !full && load_phase;
    assign rmst_req   = (state == S_REQ);
    assign push_beat  = valid && ready && !end_conv;
    assign pop_fire   = pop_req && buf_rdy && !empty && !end_conv;
    assign pop_keep   = pop_fire && recirc_en;
    assign pop_drop   = pop_fire && !recirc_en;
    assign count_next = count + CW'(push_beat) - CW'(pop_drop);
    // Space is judged on the occupancy after this cycle's push so a same-cycle last beat counts.
    assign space_ok   = (CW'(DEPTH) - count_next) >= CW'(BURST_LEN);
    assign last_burst = (burst_idx == BIDX_W'(NUM_BURSTS - 1));
    assign word_cnt   = count;
    assign o_data     = empty ? '0 : mem[rd_ptr];
    assign mem_we     = push_beat || pop_keep;
    assign mem_wdata  = push_beat ? tdata : mem[rd_ptr];

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (op_start) state_next = S_REQ;
            S_REQ:   state_next = S_WAIT;
            S_WAIT: begin
                if (rmst_done) begin
                    if (last_burst)    state_next = S_READY;
                    else if (space_ok) state_next = S_REQ;
                    else               state_next = S_HOLD;
                end
            end
            S_HOLD:  if (space_ok) state_next = S_REQ;
            S_READY: if (pop_drop && count == CW'(1)) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (end_conv) state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            buf_rdy <= 1'b0;
        end else begin
            state   <= state_next;
            buf_rdy <= (state == S_READY) && (state_next == S_READY);
        end
    end

    // The address register is bumped per completed burst, so it stays put while a request is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_idx   <= '0;
            addr_offset <= '0;
        end else if (end_conv) begin
            burst_idx   <= '0;
            addr_offset <= '0;
        end else if (state == S_IDLE && op_start) begin
            burst_idx   <= '0;
            addr_offset <= addr_base;
        end else if (state == S_WAIT && rmst_done) begin
            burst_idx   <= burst_idx + 1'b1;
            addr_offset <= addr_offset + ADDR_WIDTH'(BURST_BYTES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (end_conv) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (mem_we)   wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Loads and recirculating pops never coincide, so one write port serves both.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr] <= mem_wdata;
    end

`ifdef MBPB_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= '0;
        end else if (end_conv) begin
            err <= '0;
        end else begin
            err <= err | {rmst_done && (state != S_WAIT),
                          pop_req && !(buf_rdy && !empty),
                          valid && full && load_phase};
        end
    end
`endif

endmodule
